arbiter_mux4_24bit: RTL and testbench
=====================================

// Module: arbiter_mux4_24bit
// PURPOSE
//  Round-robin arbiter/controller sharing one 24-bit 4-to-1 datapath mux among four requesters.
//  Drives the mux select, captures the selected word into an output register and hands it
//  downstream over a valid/ready handshake. Sits between four 24-bit producers
//  (register file ports, ALU, memory) and a single 24-bit consumer bus in the CPU.
// PARAMETERS
//  WIDTH      24  data width of every input word and of Dalja
//  START_PTR  0   requester index (0..3) holding top priority after reset
// PORTS
//  Clock       in   1      single system clock; all state updates on its rising edge
//  Reset       in   1      asynchronous, active-high; clears all state immediately
//  Req         in   4      Req[i]=1: requester i holds valid data on Hyrja<i>
//  Hyrja0      in   WIDTH  data word of requester 0 (Hyrja1..Hyrja3 identical, requesters 1..3)
//  Ack         out  4      one-hot, 1-cycle pulse: word of requester i captured this edge
//  S           out  2      mux select of the current/last grant (registered)
//  Dalja       out  WIDTH  registered output word
//  DaljaValid  out  1      Dalja holds an untaken word
//  DaljaReady  in   1      consumer accepts Dalja when DaljaValid & DaljaReady at rising edge
//  Busy        out  1      =DaljaValid (state HOLD)
// BEHAVIOUR
//  Reset values: Dalja=0, DaljaValid=0, Ack=0, S=0, Busy=0, Ptr=START_PTR, state IDLE.
//  Reset mid-transfer discards the held word; no Ack or handshake completes for it.
//  Ptr (2 bit) = highest-priority index; search order Ptr, Ptr+1, Ptr+2, Ptr+3 (mod 4).
//  States:
//   IDLE: if |Req at edge: winner w = first set Req in search order; Dalja<=Hyrja<w>,
//         S<=w, DaljaValid<=1, Ack<=one-hot(w) for that cycle, Ptr<=w+1 (wraps 3->0),
//         -> HOLD. If Req==0: stay, Ack=0, outputs hold.
//   HOLD: Dalja, S held stable while DaljaValid=1 and DaljaReady=0 (no new grant, Ack=0).
//         On DaljaValid&DaljaReady: if |Req, grant next winner same edge (back-to-back,
//         one word per cycle, stay HOLD); else DaljaValid<=0 -> IDLE.
//  Ack is high exactly the cycle after the capturing edge and for one cycle only; requester i
//   must drop Req[i] or present a new word by the following edge (Req sampled again).
//  A Req held continuously is served at most every 4th grant when all four request;
//   worst-case wait = 3 completed transfers after becoming eligible.
//  Latency: Req sampled at edge n -> Dalja/DaljaValid valid after edge n (1 cycle).
//  Req changes while in HOLD with ready low have no effect until the completing edge.
//  Ack asserted in the same cycle for at most one bit; never asserted during Reset.
//  Single requester repeatedly: served back-to-back each cycle DaljaReady=1.
//  No arithmetic beyond 2-bit Ptr/winner increments, modulo 4.
// TESTING
//  1 Reset then Req=4'b0100, Hyrja2=24'hABCDEF, DaljaReady=1 -> next cycle Dalja=ABCDEF,
//    DaljaValid=1, S=2, Ack=4'b0100; Ptr=3.
//  2 All Req=4'b1111 held, DaljaReady=1, distinct data -> grant order 0,1,2,3,0; one Ack per
//    cycle, Dalja tracks granted word every cycle.
//  3 Backpressure: grant req1 (24'h000111), DaljaReady=0 for 5 cycles while Req changes ->
//    Dalja=000111, S=1 stable, Ack=0; ready=1 then completes and next grant issues.
//  4 Wrap: Ptr=3, Req=4'b1001 -> grants 3 then 0; Ptr wraps 3->0->1.
//  5 Async Reset pulse mid-HOLD (between edges) -> DaljaValid, Dalja, S, Ack go 0 immediately;
//    after release Req=4'b0001 -> requester START_PTR order resumes, grant 0.
//  6 Req=0 with DaljaReady toggling -> DaljaValid stays 0, Ack stays 0, state IDLE.

Source files
------------

// File: rtl/arbiter_mux4_24bit.sv
// Round-robin arbiter driving a shared 4:1 word mux into a registered
// output stage with a valid/ready handshake toward a single consumer.
module arbiter_mux4_24bit #(
    parameter int WIDTH     = 24,
    parameter int START_PTR = 0
) (
    input  logic             Clock,
    input  logic             Reset,
    input  logic [3:0]       Req,
    input  logic [WIDTH-1:0] Hyrja0,
    input  logic [WIDTH-1:0] Hyrja1,
    input  logic [WIDTH-1:0] Hyrja2,
    input  logic [WIDTH-1:0] Hyrja3,
    output logic [3:0]       Ack,
    output logic [1:0]       S,
    output logic [WIDTH-1:0] Dalja,
    output logic             DaljaValid,
    input  logic             DaljaReady,
    output logic             Busy
);

    typedef enum logic {
        IDLE,
        HOLD
    } state_t;

    state_t           state;
    logic [1:0]       ptr;
    logic [1:0]       win;
    logic [1:0]       idx;
    logic             found;
    logic [WIDTH-1:0] sel;
    logic             slot_free;
    logic             grant;

    // First set request scanning ptr, ptr+1, ptr+2, ptr+3 (mod 4)
    always_comb begin
        win   = 2'd0;
        idx   = 2'd0;
        found = 1'b0;
        for (int k = 0; k < 4; k++) begin
            idx = ptr + 2'(k);
            if (!found && Req[idx]) begin
                win   = idx;
                found = 1'b1;
            end
        end
    end

    always_comb begin
        sel = '0;
        unique case (win)
            2'd0: sel = Hyrja0;
            2'd1: sel = Hyrja1;
            2'd2: sel = Hyrja2;
            2'd3: sel = Hyrja3;
        endcase
    end

    // Output slot can take a new word when empty or being drained this edge
    assign slot_free = (state == IDLE) || DaljaReady;
    assign grant     = slot_free && found;
    assign Busy      = DaljaValid;

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state      <= IDLE;
            ptr        <= 2'(START_PTR);
            Dalja      <= '0;
            DaljaValid <= 1'b0;
            Ack        <= 4'b0000;
            S          <= 2'd0;
        end else begin
            Ack <= 4'b0000;
            if (grant) begin
                Dalja      <= sel;
                S          <= win;
                DaljaValid <= 1'b1;
                Ack        <= 4'b0001 << win;
                ptr        <= win + 2'd1;
                state      <= HOLD;
            end else if (state == HOLD && DaljaReady) begin
                DaljaValid <= 1'b0;
                state      <= IDLE;
            end
        end
    end

endmodule

// File: tb/tb_arbiter_mux4_24bit.sv
// Bench for arbiter_mux4_24bit: vector table, corner sequences and
// randomized traffic against a queue-free round-robin reference model.
module tb_arbiter_mux4_24bit;

    logic        Clock = 1'b0;
    logic        Reset;
    logic [3:0]  Req;
    logic [23:0] h[4];
    logic [3:0]  Ack;
    logic [1:0]  S;
    logic [23:0] Dalja;
    logic        DaljaValid;
    logic        DaljaReady;
    logic        Busy;

    int ncmp = 0;
    int nerr = 0;

    int          mptr;
    bit          mvalid;
    logic [23:0] mdat;
    int          ms;
    logic [3:0]  mack;

    typedef struct {
        logic [3:0]  req;
        logic        rdy;
        logic [3:0]  ack;
        logic [1:0]  s;
        logic        valid;
        logic [23:0] dat;
    } vec_t;

    vec_t tv[9];

    always #5 Clock = ~Clock;

    arbiter_mux4_24bit #(.WIDTH(24), .START_PTR(0)) dut (
        .Clock(Clock),
        .Reset(Reset),
        .Req(Req),
        .Hyrja0(h[0]),
        .Hyrja1(h[1]),
        .Hyrja2(h[2]),
        .Hyrja3(h[3]),
        .Ack(Ack),
        .S(S),
        .Dalja(Dalja),
        .DaljaValid(DaljaValid),
        .DaljaReady(DaljaReady),
        .Busy(Busy)
    );

    task automatic chk(input string n, input logic [31:0] a,
                       input logic [31:0] e);
        ncmp++;
        if (a !== e) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h", n, a, e);
        end
    endtask

    function automatic void mreset();
        mptr   = 0;
        mvalid = 0;
        mdat   = 0;
        ms     = 0;
        mack   = 0;
    endfunction

    // Reference: slot accepts a word if empty or drained; winner is the
    // first requester at distance 0..3 from the priority pointer.
    function automatic void model_step();
        int w;
        if (Reset) begin
            mreset();
            return;
        end
        mack = 0;
        if (!mvalid || DaljaReady) begin
            if (Req != 0) begin
                w = -1;
                for (int k = 0; k < 4; k++)
                    if (w < 0 && Req[(mptr + k) % 4]) w = (mptr + k) % 4;
                mdat   = h[w];
                ms     = w;
                mvalid = 1;
                mack   = 4'(1 << w);
                mptr   = (w + 1) % 4;
            end else begin
                mvalid = 0;
            end
        end
    endfunction

    task automatic tick();
        @(posedge Clock);
        model_step();
        #1;
    endtask

    task automatic next();
        @(negedge Clock);
    endtask

    task automatic chk_model(input string n);
        chk({n, " ack"}, 32'(Ack), 32'(mack));
        chk({n, " s"}, 32'(S), 32'(ms));
        chk({n, " valid"}, 32'(DaljaValid), 32'(mvalid));
        chk({n, " busy"}, 32'(Busy), 32'(mvalid));
        chk({n, " dalja"}, 32'(Dalja), 32'(mdat));
    endtask

    initial begin
        Reset      = 1'b1;
        Req        = 4'b0000;
        DaljaReady = 1'b0;
        h[0] = 24'h100000;
        h[1] = 24'h200001;
        h[2] = 24'hABCDEF;
        h[3] = 24'h400003;
        mreset();

        tv[0] = '{4'b0100, 1'b1, 4'b0100, 2'd2, 1'b1, 24'hABCDEF};
        tv[1] = '{4'b1001, 1'b1, 4'b1000, 2'd3, 1'b1, 24'h400003};
        tv[2] = '{4'b1001, 1'b1, 4'b0001, 2'd0, 1'b1, 24'h100000};
        tv[3] = '{4'b1111, 1'b1, 4'b0010, 2'd1, 1'b1, 24'h200001};
        tv[4] = '{4'b1111, 1'b1, 4'b0100, 2'd2, 1'b1, 24'hABCDEF};
        tv[5] = '{4'b1111, 1'b1, 4'b1000, 2'd3, 1'b1, 24'h400003};
        tv[6] = '{4'b1111, 1'b1, 4'b0001, 2'd0, 1'b1, 24'h100000};
        tv[7] = '{4'b0000, 1'b1, 4'b0000, 2'd0, 1'b0, 24'h100000};
        tv[8] = '{4'b0000, 1'b0, 4'b0000, 2'd0, 1'b0, 24'h100000};

        tick();
        tick();
        chk("rst ack", 32'(Ack), 0);
        chk("rst s", 32'(S), 0);
        chk("rst valid", 32'(DaljaValid), 0);
        chk("rst busy", 32'(Busy), 0);
        chk("rst dalja", 32'(Dalja), 0);
        next();
        Reset = 1'b0;

        for (int i = 0; i < 9; i++) begin
            Req        = tv[i].req;
            DaljaReady = tv[i].rdy;
            tick();
            chk($sformatf("v%0d ack", i), 32'(Ack), 32'(tv[i].ack));
            chk($sformatf("v%0d s", i), 32'(S), 32'(tv[i].s));
            chk($sformatf("v%0d valid", i), 32'(DaljaValid),
                32'(tv[i].valid));
            chk($sformatf("v%0d dalja", i), 32'(Dalja), 32'(tv[i].dat));
            next();
        end

        // Backpressure: held word survives request churn
        Reset = 1'b1;
        tick();
        next();
        Reset      = 1'b0;
        h[1]       = 24'h000111;
        Req        = 4'b0010;
        DaljaReady = 1'b0;
        tick();
        chk("bp grant ack", 32'(Ack), 32'h2);
        chk("bp grant dalja", 32'(Dalja), 32'h000111);
        next();
        for (int i = 0; i < 5; i++) begin
            Req = 4'($urandom);
            tick();
            chk($sformatf("bp%0d dalja", i), 32'(Dalja), 32'h000111);
            chk($sformatf("bp%0d s", i), 32'(S), 1);
            chk($sformatf("bp%0d ack", i), 32'(Ack), 0);
            chk($sformatf("bp%0d valid", i), 32'(DaljaValid), 1);
            next();
        end
        h[0]       = 24'h000AAA;
        Req        = 4'b0001;
        DaljaReady = 1'b1;
        tick();
        chk("bp done ack", 32'(Ack), 32'h1);
        chk("bp done s", 32'(S), 0);
        chk("bp done dalja", 32'(Dalja), 32'h000AAA);
        next();

        // Async reset between edges while holding a word
        Req        = 4'b1111;
        DaljaReady = 1'b0;
        tick();
        next();
        #2;
        Reset = 1'b1;
        mreset();
        #1;
        chk("areset valid", 32'(DaljaValid), 0);
        chk("areset dalja", 32'(Dalja), 0);
        chk("areset s", 32'(S), 0);
        chk("areset ack", 32'(Ack), 0);
        tick();
        chk("areset edge ack", 32'(Ack), 0);
        next();
        Reset      = 1'b0;
        DaljaReady = 1'b1;
        tick();
        chk("resume ack", 32'(Ack), 32'h1);
        chk("resume s", 32'(S), 0);
        next();

        // No requests while ready toggles
        Req = 4'b0000;
        tick();
        next();
        for (int i = 0; i < 6; i++) begin
            DaljaReady = i[0];
            tick();
            chk($sformatf("idle%0d valid", i), 32'(DaljaValid), 0);
            chk($sformatf("idle%0d ack", i), 32'(Ack), 0);
            next();
        end

        // Randomized traffic against the reference model
        for (int i = 0; i < 2000; i++) begin
            Reset      = ($urandom % 150) == 0;
            Req        = ($urandom % 4 == 0) ? 4'b1111 : 4'($urandom);
            DaljaReady = ($urandom % 3) != 0;
            for (int j = 0; j < 4; j++) h[j] = 24'($urandom);
            tick();
            chk_model($sformatf("rnd%0d", i));
            next();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
        $finish;
    end

endmodule
